// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the (2,1,3) convolutional-code / Viterbi loopback link.
// Feeds one payload frame plus zero flush bits into the encoder, then scores
// the decoder output against the captured payload.
module conv_frame_ctrl #(
    parameter int unsigned FRAME_LEN   = 64,
    parameter int unsigned TAIL_LEN    = 2,
    parameter int unsigned DEC_TIMEOUT = 512,
    parameter int unsigned CW          = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          src_bit,
    output logic          src_req,
    output logic          enc_bit,
    output logic          enc_en,
    input  logic          dec_bit,
    input  logic          dec_valid,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] err_cnt,
    output logic [15:0]   frame_cnt,
    output logic [31:0]   total_err
);

    localparam int unsigned XW = $clog2(FRAME_LEN + 1);
    localparam int unsigned IW = $clog2(FRAME_LEN);
    localparam int unsigned TW = (TAIL_LEN > 2) ? $clog2(TAIL_LEN) : 1;
    localparam int unsigned DW = (DEC_TIMEOUT > 2) ? $clog2(DEC_TIMEOUT) : 1;

    localparam logic [XW-1:0] LEN_X      = XW'(FRAME_LEN);
    localparam logic [XW-1:0] TX_LAST    = XW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] TAIL_LAST  = TW'(TAIL_LEN - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DEC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_TAIL,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [XW-1:0]          tx_idx_q, tx_idx_d;
    logic [XW-1:0]          rx_idx_q, rx_idx_d;
    logic [TW-1:0]          tail_q, tail_d;
    logic [DW-1:0]          drain_q, drain_d;
    logic [FRAME_LEN-1:0]   payload_q, payload_d;
    logic [CW-1:0]          err_q, err_d;
    logic                   timeout_q, timeout_d;
    logic [15:0]            frame_q, frame_d;
    logic [31:0]            total_q, total_d;
    logic [32:0]            total_sum;
    logic                   collect;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tx_idx_q  <= '0;
            rx_idx_q  <= '0;
            tail_q    <= '0;
            drain_q   <= '0;
            payload_q <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
            frame_q   <= '0;
            total_q   <= '0;
        end else begin
            state_q   <= state_d;
            tx_idx_q  <= tx_idx_d;
            rx_idx_q  <= rx_idx_d;
            tail_q    <= tail_d;
            drain_q   <= drain_d;
            payload_q <= payload_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            frame_q   <= frame_d;
            total_q   <= total_d;
        end
    end

    // Next-state, decode scoring and state-decoded outputs
    always_comb begin
        state_d   = state_q;
        tx_idx_d  = tx_idx_q;
        rx_idx_d  = rx_idx_q;
        tail_d    = tail_q;
        drain_d   = drain_q;
        payload_d = payload_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        frame_d   = frame_q;
        total_d   = total_q;
        src_req   = 1'b0;
        enc_bit   = 1'b0;
        enc_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        total_sum = {1'b0, total_q} + 33'(err_q);
        collect   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FEED;
                    tx_idx_d  = '0;
                    rx_idx_d  = '0;
                    tail_d    = '0;
                    drain_d   = '0;
                    err_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            S_FEED: begin
                enc_en  = 1'b1;
                src_req = 1'b1;
                busy    = 1'b1;
                enc_bit = src_bit;
                collect = 1'b1;
                payload_d[IW'(tx_idx_q)] = src_bit;
                tx_idx_d = tx_idx_q + XW'(1);
                if (tx_idx_q == TX_LAST) begin
                    state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                enc_en  = 1'b1;
                busy    = 1'b1;
                collect = 1'b1;
                tail_d  = tail_q + TW'(1);
                if (tail_q == TAIL_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                collect = 1'b1;
                drain_d = drain_q + DW'(1);
            end
            S_DONE: begin
                done    = 1'b1;
                frame_d = frame_q + 16'd1;
                total_d = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A decoded bit ahead of the transmitter cannot be right, so it scores as an error
        if (collect && dec_valid && (rx_idx_q < LEN_X)) begin
            if ((rx_idx_q >= tx_idx_q) || (dec_bit != payload_q[IW'(rx_idx_q)])) begin
                err_d = err_d + CW'(1);
            end
            rx_idx_d = rx_idx_q + XW'(1);
        end

        // Drain exit: complete frame wins over a same-cycle timeout
        if (state_q == S_DRAIN) begin
            if (rx_idx_d == LEN_X) begin
                state_d = S_DONE;
            end else if (drain_q == DRAIN_LAST) begin
                timeout_d = 1'b1;
                err_d     = err_d + CW'(LEN_X - rx_idx_d);
                state_d   = S_DONE;
            end
        end
    end

    assign timeout   = timeout_q;
    assign err_cnt   = err_q;
    assign frame_cnt = frame_q;
    assign total_err = total_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl: table-driven and randomized frames scored by a
// frame-level reference model of the link.
module tb_conv_frame_ctrl;

    localparam int unsigned FL = 8;
    localparam int unsigned TL = 2;
    localparam int unsigned DT = 16;
    localparam int unsigned CW = 8;
    localparam int DRAIN0     = 1 + FL + TL;     // first DRAIN cycle after start cycle 0
    localparam int LAST_DRAIN = DRAIN0 + DT - 1; // last cycle a decoded bit can still count

    logic          clk;
    logic          reset;
    logic          start;
    logic          src_bit;
    logic          src_req;
    logic          enc_bit;
    logic          enc_en;
    logic          dec_bit;
    logic          dec_valid;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] err_cnt;
    logic [15:0]   frame_cnt;
    logic [31:0]   total_err;

    conv_frame_ctrl #(
        .FRAME_LEN  (FL),
        .TAIL_LEN   (TL),
        .DEC_TIMEOUT(DT),
        .CW         (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_bit  (src_bit),
        .src_req  (src_req),
        .enc_bit  (enc_bit),
        .enc_en   (enc_en),
        .dec_bit  (dec_bit),
        .dec_valid(dec_valid),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .err_cnt  (err_cnt),
        .frame_cnt(frame_cnt),
        .total_err(total_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned exp_frames = 0;
    int unsigned exp_total  = 0;

    typedef struct {
        logic [FL-1:0] flip;
        int            dly;
        int            nv;
        bit            stray;
        int            exp_err;
        bit            exp_to;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame starting this cycle; flip = decoded bits to corrupt, dly = decode
    // latency past the send cycle, nv = how many payload bits the decoder delivers.
    task automatic run_frame(input logic [FL-1:0] payload, input logic [FL-1:0] flip,
                             input int dly, input int nv, input bit stray, input bit bubbles,
                             input bit use_tbl, input int t_err, input bit t_to);
        int p[FL];
        int counted;
        int m_err;
        bit m_to;
        int done_c;
        int e_err;
        bit e_to;
        logic [4:0] exp_o;
        p[0] = 1 + dly;
        for (int k = 1; k < int'(FL); k++)
            p[k] = p[k-1] + 1 + ((bubbles && $urandom_range(0, 3) == 0) ? 1 : 0);

        // Reference: in-order delivery, bit k is sent during cycle k+1 and counts as
        // an error if presented before the cycle after it was sent.
        counted = 0;
        m_err   = 0;
        for (int k = 0; k < nv; k++) begin
            if (p[k] <= LAST_DRAIN) begin
                counted++;
                if (p[k] < k + 2 || flip[k]) m_err++;
            end
        end
        m_to = (counted < int'(FL));
        if (m_to) m_err += int'(FL) - counted;
        if (m_to) done_c = LAST_DRAIN + 1;
        else done_c = (p[FL-1] + 1 > DRAIN0 + 1) ? p[FL-1] + 1 : DRAIN0 + 1;
        e_err = use_tbl ? t_err : m_err;
        e_to  = use_tbl ? t_to  : m_to;

        for (int c = 0; c <= done_c; c++) begin
            start     = (c == 0) || (stray && $urandom_range(0, 2) == 0);
            src_bit   = (c >= 1 && c <= int'(FL)) ? payload[c-1] : 1'($urandom);
            dec_valid = 1'b0;
            dec_bit   = 1'($urandom);
            for (int k = 0; k < nv; k++) begin
                if (p[k] == c) begin
                    dec_valid = 1'b1;
                    dec_bit   = payload[k] ^ flip[k];
                end
            end
            if (nv == int'(FL) && (c == p[FL-1] + 1 || c == p[FL-1] + 2)) begin
                dec_valid = 1'b1;
            end
            #1;
            exp_o[4] = (c >= 1 && c <= int'(FL + TL));
            exp_o[3] = (c >= 1 && c <= int'(FL));
            exp_o[2] = (c >= 1 && c <= int'(FL)) ? payload[c-1] : 1'b0;
            exp_o[1] = (c >= 1 && c < done_c);
            exp_o[0] = (c == done_c);
            chk($sformatf("outs_c%0d{en,req,bit,busy,done}", c),
                64'({enc_en, src_req, enc_bit, busy, done}), 64'(exp_o));
            if (c == done_c) begin
                chk("err_cnt_at_done", 64'(err_cnt), 64'(e_err));
                chk("timeout_at_done", 64'(timeout), 64'(e_to));
            end
            tick();
        end
        start     = 1'b0;
        dec_valid = 1'b0;
        exp_frames = exp_frames + 1;
        exp_total  = exp_total + e_err;
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames & 32'hFFFF));
        chk("total_err", 64'(total_err), 64'(exp_total));
        chk("err_cnt_hold", 64'(err_cnt), 64'(e_err));
        chk("timeout_hold", 64'(timeout), 64'(e_to));
    endtask

    task automatic do_reset(input bit with_start);
        reset = 1'b1;
        start = with_start;
        tick();
        chk("in_reset_outs", 64'({src_req, enc_bit, enc_en, busy, done, timeout, err_cnt, frame_cnt, total_err}), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_after_reset", 64'({src_req, enc_en, busy, done}), 64'd0);
        exp_frames = 0;
        exp_total  = 0;
    endtask

    initial begin
        logic [FL-1:0] pl;
        reset = 1'b1; start = 1'b0; src_bit = 1'b0; dec_bit = 1'b0; dec_valid = 1'b0;
        tbl[0]  = '{8'h00, 2,  8, 1'b0, 0, 1'b0};
        tbl[1]  = '{8'h48, 2,  8, 1'b0, 2, 1'b0};
        tbl[2]  = '{8'h00, 2,  0, 1'b0, 8, 1'b1};
        tbl[3]  = '{8'h00, 3,  8, 1'b1, 0, 1'b0};
        tbl[4]  = '{8'h01, 18, 8, 1'b0, 1, 1'b0};
        tbl[5]  = '{8'h02, 1,  5, 1'b0, 4, 1'b1};
        tbl[6]  = '{8'h00, 0,  8, 1'b0, 8, 1'b0};
        tbl[7]  = '{8'hFF, 1,  8, 1'b0, 8, 1'b0};
        tbl[8]  = '{8'h07, 2,  8, 1'b0, 3, 1'b0};
        tbl[9]  = '{8'h70, 4,  8, 1'b0, 3, 1'b0};
        tbl[10] = '{8'h29, 1,  8, 1'b0, 3, 1'b0};
        tbl[11] = '{8'h92, 3,  8, 1'b0, 3, 1'b0};

        tick();
        do_reset(1'b1);
        repeat (3) tick();

        for (int i = 0; i < 8; i++) begin
            pl = FL'($urandom);
            run_frame(pl, tbl[i].flip, tbl[i].dly, tbl[i].nv, tbl[i].stray, 1'b0,
                      1'b1, tbl[i].exp_err, tbl[i].exp_to);
        end

        for (int i = 0; i < 20; i++) begin
            int nv;
            pl = FL'($urandom);
            nv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FL - 1)) : int'(FL);
            run_frame(pl, FL'($urandom), int'($urandom_range(0, 5)), nv,
                      1'($urandom), 1'b1, 1'b0, 0, 1'b0);
        end

        // Abort mid-FEED with four payload bits already taken
        pl = FL'($urandom);
        start = 1'b1;
        src_bit = pl[0];
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            src_bit = (k < int'(FL)) ? pl[k] : 1'b0;
            tick();
        end
        chk("feed_before_abort{req,busy}", 64'({src_req, busy}), 64'b11);
        reset = 1'b1;
        src_bit = 1'b1;
        dec_valid = 1'b1;
        tick();
        reset = 1'b0;
        dec_valid = 1'b0;
        chk("abort_outs", 64'({src_req, enc_bit, enc_en, busy, done, timeout, err_cnt, frame_cnt, total_err}), 64'd0);
        exp_frames = 0;
        exp_total  = 0;
        tick();
        chk("no_done_after_abort", 64'({done, busy, frame_cnt}), 64'd0);
        pl = FL'($urandom);
        run_frame(pl, 8'h00, 2, FL, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        // Four back-to-back frames with three errors each from a cleared state
        do_reset(1'b0);
        for (int i = 8; i < 12; i++) begin
            pl = FL'($urandom);
            run_frame(pl, tbl[i].flip, tbl[i].dly, tbl[i].nv, tbl[i].stray, 1'b0,
                      1'b1, tbl[i].exp_err, tbl[i].exp_to);
        end
        chk("b2b_frame_cnt", 64'(frame_cnt), 64'd4);
        chk("b2b_total_err", 64'(total_err), 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
